// File: rtl/comp_arbiter_if.sv
// comp_arbiter_if: request/response bundle for the shared comparator.
//   req_valid/req_ready : per-requester handshake (ready is a one-hot grant)
//   req_a/req_b         : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : result handshake toward the consumer
//   rsp_id              : index of the requester the result belongs to
//   rsp_lt/eq/gt        : one-hot compare result
// master = requesters plus consumer, slave = the arbiter.
interface comp_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_lt;
  logic               rsp_eq;
  logic               rsp_gt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt
  );
endinterface

// File: rtl/comp_arbiter.sv
// comp_arbiter: one magnitude comparator shared by N_REQ requesters.
// A round-robin grant picks one requester in IDLE, its operands are captured,
// compared in CMP, and the tagged result is held in RESP until accepted.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : comp_arbiter_if.slave (request and response handshakes)
module comp_arbiter #(
  parameter int N_REQ  = 4,
  parameter int W      = 16,
  parameter int SIGNED = 0
) (
  input logic           clk,
  input logic           rst,
  comp_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t         state_reg;
  logic [IDW-1:0] last_grant_reg;
  logic [IDW-1:0] cur_id_reg;
  logic [W-1:0]   op_a_reg;
  logic [W-1:0]   op_b_reg;
  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic           rsp_lt_reg;
  logic           rsp_eq_reg;
  logic           rsp_gt_reg;

  // Unpacked views of the packed operand buses.
  logic [W-1:0] a_arr [N_REQ];
  logic [W-1:0] b_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*W +: W];
      assign b_arr[gi] = bus.req_b[gi*W +: W];
    end
  endgenerate

  // Round-robin search starting just after the last granted requester.
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic             found;
  int               idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_reg) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        grant_id = IDW'(idx);
      end
    end
    // Grant only in IDLE, and never while reset is held.
    if (found && state_reg == IDLE && !rst) grant[grant_id] = 1'b1;
  end

  logic lt_c, eq_c, gt_c;

  generate
    if (SIGNED != 0) begin : g_signed
      assign lt_c = $signed(op_a_reg) < $signed(op_b_reg);
      assign gt_c = $signed(op_a_reg) > $signed(op_b_reg);
    end else begin : g_unsigned
      assign lt_c = op_a_reg < op_b_reg;
      assign gt_c = op_a_reg > op_b_reg;
    end
  endgenerate
  assign eq_c = (op_a_reg == op_b_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(N_REQ - 1);
      cur_id_reg     <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_lt_reg     <= 1'b0;
      rsp_eq_reg     <= 1'b0;
      rsp_gt_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            op_a_reg   <= a_arr[grant_id];
            op_b_reg   <= b_arr[grant_id];
            cur_id_reg <= grant_id;
            state_reg  <= CMP;
          end
        end
        CMP: begin
          rsp_lt_reg    <= lt_c;
          rsp_eq_reg    <= eq_c;
          rsp_gt_reg    <= gt_c;
          rsp_id_reg    <= cur_id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          // Pointer advances only once the result has left the block.
          if (bus.rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
            last_grant_reg <= cur_id_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_lt    = rsp_lt_reg;
  assign bus.rsp_eq    = rsp_eq_reg;
  assign bus.rsp_gt    = rsp_gt_reg;
endmodule

// File: tb/tb_comp_arbiter.sv
module tb_comp_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_ready = 1'b1;

  always #5 clk = ~clk;

  comp_arbiter_if #(.N_REQ(N), .W(W)) bus_u ();
  comp_arbiter_if #(.N_REQ(N), .W(W)) bus_s ();

  assign bus_u.req_valid = req_valid;
  assign bus_u.req_a     = req_a;
  assign bus_u.req_b     = req_b;
  assign bus_u.rsp_ready = rsp_ready;
  assign bus_s.req_valid = req_valid;
  assign bus_s.req_a     = req_a;
  assign bus_s.req_b     = req_b;
  assign bus_s.rsp_ready = rsp_ready;

  comp_arbiter #(.N_REQ(N), .W(W), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(bus_u));
  comp_arbiter #(.N_REQ(N), .W(W), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         id;
    logic [2:0] flags;
    int         gcyc;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];
  logic [2:0] exp_uf [N];
  logic [2:0] exp_sf [N];
  int grant_log[$];

  // Reference arbiter: predicts each grant and pushes the expected response.
  int m_last = N - 1;
  bit m_busy = 1'b0;
  int m_cur  = 0;

  always @(negedge clk) begin
    logic [N-1:0] er;
    int gid;
    int idx;
    exp_t e;
    if (rst) begin
      m_busy = 1'b0;
      m_last = N - 1;
      q_u.delete();
      q_s.delete();
      chk("ready_in_reset_u", bus_u.req_ready, 0);
      chk("ready_in_reset_s", bus_s.req_ready, 0);
    end else begin
      er  = '0;
      gid = -1;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (gid < 0 && req_valid[idx]) gid = idx;
        end
      end
      if (gid >= 0) er[gid] = 1'b1;
      chk("req_ready_u", bus_u.req_ready, er);
      chk("req_ready_s", bus_s.req_ready, er);
      if (gid >= 0) begin
        e.id = gid; e.gcyc = cyc;
        e.flags = exp_uf[gid]; q_u.push_back(e);
        e.flags = exp_sf[gid]; q_s.push_back(e);
        m_busy = 1'b1;
        m_cur  = gid;
        grant_log.push_back(gid);
        $display("grant r%0d at cycle %0d", gid, cyc);
      end else if (m_busy && bus_u.rsp_valid && rsp_ready) begin
        m_busy = 1'b0;
        m_last = m_cur;
      end
    end
  end

  // Response monitor: compares every presented response against the queue head.
  bit prev_v [2];

  task automatic mon_one(input int k, input logic v, input logic [1:0] id,
                         input logic [2:0] fl);
    exp_t e;
    bit have;
    string tag;
    tag  = (k == 0) ? "u" : "s";
    have = 1'b0;
    if (k == 0) begin
      if (q_u.size() > 0) begin have = 1'b1; e = q_u[0]; end
    end else begin
      if (q_s.size() > 0) begin have = 1'b1; e = q_s[0]; end
    end
    if (!have) begin
      chk({"rsp_valid_idle_", tag}, v, 0);
    end else if (v) begin
      chk({"rsp_id_", tag}, id, e.id);
      chk({"rsp_flags_", tag}, fl, e.flags);
      if (!prev_v[k]) chk({"rsp_latency_", tag}, cyc - e.gcyc, 2);
      if (rsp_ready) begin
        $display("rsp[%s] id=%0d flags=%b at cycle %0d", tag, id, fl, cyc);
        if (k == 0) void'(q_u.pop_front()); else void'(q_s.pop_front());
      end
    end else if (cyc >= e.gcyc + 2) begin
      chk({"rsp_timeout_", tag}, v, 1);
      if (k == 0) void'(q_u.pop_front()); else void'(q_s.pop_front());
    end
    prev_v[k] = v;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
      chk("rsp_valid_in_reset", {bus_u.rsp_valid, bus_s.rsp_valid}, 0);
    end else begin
      mon_one(0, bus_u.rsp_valid, bus_u.rsp_id, {bus_u.rsp_lt, bus_u.rsp_eq, bus_u.rsp_gt});
      mon_one(1, bus_s.rsp_valid, bus_s.rsp_id, {bus_s.rsp_lt, bus_s.rsp_eq, bus_s.rsp_gt});
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] eu, input logic [2:0] es);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    exp_uf[i] = eu;
    exp_sf[i] = es;
    req_valid[i] = 1'b1;
  endtask

  // Waits for requester i's grant; returns just after the transfer edge.
  task automatic wait_grant(input int i, output int gc, output logic [N-1:0] rdy);
    bit got;
    got = 1'b0;
    gc  = -1;
    rdy = '0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (bus_u.req_ready[i]) begin
        got = 1'b1;
        gc  = cyc;
        rdy = bus_u.req_ready;
      end
    end
    chk($sformatf("grant_wait_r%0d", i), got, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_u"}, {bus_u.req_ready, bus_u.rsp_valid, bus_u.rsp_id,
                       bus_u.rsp_lt, bus_u.rsp_eq, bus_u.rsp_gt}, 0);
    chk({name, "_s"}, {bus_s.req_ready, bus_s.rsp_valid, bus_s.rsp_id,
                       bus_s.rsp_lt, bus_s.rsp_eq, bus_s.rsp_gt}, 0);
  endtask

  initial begin
    int g1, g2, r, start;
    bit seen;
    logic [N-1:0] rdy;

    // Reset state, with requests pending to show grants are suppressed.
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset_outputs");
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single unsigned request, then back-to-back throughput.
    set_req(2, 16'h003D, 16'h003E, LT, LT);
    wait_grant(2, g1, rdy);
    chk("t1_ready_onehot", rdy, 4'b0100);
    req_valid[2] = 1'b0;
    set_req(3, 16'h0100, 16'h0100, EQ, EQ);
    wait_grant(3, g2, rdy);
    req_valid[3] = 1'b0;
    chk("t1_next_grant_gap", g2 - g1, 3);

    // All four requesters held: rotation 0,1,2,3,0,1.
    start = grant_log.size();
    set_req(0, 16'h0001, 16'h0002, LT, LT);
    set_req(1, 16'h0005, 16'h0005, EQ, EQ);
    set_req(2, 16'h9000, 16'h1000, GT, LT);
    set_req(3, 16'h0002, 16'h0001, GT, GT);
    for (int n = 0; n < 200 && grant_log.size() < start + 6; n++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rotation_count", grant_log.size() - start, 6);
    if (grant_log.size() >= start + 6) begin
      chk("rotation_0", grant_log[start+0], 0);
      chk("rotation_1", grant_log[start+1], 1);
      chk("rotation_2", grant_log[start+2], 2);
      chk("rotation_3", grant_log[start+3], 3);
      chk("rotation_4", grant_log[start+4], 0);
      chk("rotation_5", grant_log[start+5], 1);
    end
    for (int n = 0; n < 20 && q_u.size() > 0; n++) @(negedge clk);
    @(posedge clk); #1;

    // Backpressure with a second request pending (pointer now at 1).
    rsp_ready = 1'b0;
    set_req(3, 16'h1234, 16'h1234, EQ, EQ);
    set_req(0, 16'hFFFF, 16'h0000, GT, LT);
    wait_grant(3, g1, rdy);
    req_valid[3] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = bus_u.rsp_valid;
    end
    chk("bp_rsp_seen", seen, 1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready_held_zero", bus_u.req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    r = cyc;
    wait_grant(0, g2, rdy);
    req_valid[0] = 1'b0;
    chk("bp_next_grant_gap", g2 - r, 1);

    // Signed boundary 0x8000 vs 0x7FFF.
    set_req(1, 16'h8000, 16'h7FFF, GT, LT);
    wait_grant(1, g1, rdy);
    req_valid[1] = 1'b0;

    // Operands changed and valid dropped during CMP must be ignored.
    set_req(1, 16'h0010, 16'h0020, LT, LT);
    wait_grant(1, g1, rdy);
    req_a[1*W +: W] = 16'hFFFF;
    req_valid[1] = 1'b0;
    for (int n = 0; n < 20 && q_u.size() > 0; n++) @(negedge clk);
    @(posedge clk); #1;

    // Reset during CMP aborts the transaction and restores the pointer.
    set_req(2, 16'h0001, 16'h0000, GT, GT);
    wait_grant(2, g1, rdy);
    req_valid[2] = 1'b0;
    set_req(1, 16'h0003, 16'h0007, LT, LT);
    set_req(3, 16'h0007, 16'h0003, GT, GT);
    #1;
    rst = 1'b1;
    #1;
    chk_outputs_zero("async_reset_outputs");
    @(posedge clk); #3;
    rst = 1'b0;
    start = grant_log.size();
    wait_grant(1, g1, rdy);
    req_valid[1] = 1'b0;
    chk("post_reset_first_grant", (grant_log.size() > start) ? grant_log[start] : -1, 1);
    wait_grant(3, g2, rdy);
    req_valid[3] = 1'b0;

    for (int n = 0; n < 50 && (q_u.size() > 0 || q_s.size() > 0); n++) @(negedge clk);
    chk("queues_drained", q_u.size() + q_s.size(), 0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
